// File: rtl/keyboard_key_decoder_pkg.sv
// Shared constants and types for the PS/2 keyboard path.
// Default scancodes map W/S/Space/Enter to throttle/gear down/gear up/start.
package keyboard_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] KEY0_DEF = 8'h1D;
  localparam logic [7:0] KEY1_DEF = 8'h1B;
  localparam logic [7:0] KEY2_DEF = 8'h29;
  localparam logic [7:0] KEY3_DEF = 8'h5A;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } dec_state_t;

endpackage

// File: rtl/keyboard_key_decoder_if.sv
// Pin-side and decoded-side signals of the keyboard decoder.
// master is the decoder; slave is whatever drives pins and reads keys.
interface keyboard_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key_pressed;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;

  modport master (
    input  ps2_clk, ps2_data,
    output key_pressed, rx_byte, rx_valid, rx_error
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  key_pressed, rx_byte, rx_valid, rx_error
  );
endinterface

// File: rtl/keyboard_key_decoder_ps2_rx.sv
// PS/2 frame receiver: pin sync, falling-edge sampling, frame checks
// and an inactivity timeout that abandons half-received frames.
module ps2_rx
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST = 4'(FRAME_BITS - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_d;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [10:0]   frame;
  logic          frame_ok;
  logic [TW-1:0] timer;
  logic          timeout;

  assign fall     = clk_d & ~clk_sync[1];
  assign frame    = {dat_sync[1], shreg};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
  // A fall in the same cycle beats the timeout
  assign timeout  = (bit_cnt != 4'd0) && !fall &&
                    (timer == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_d    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_d    <= clk_sync[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 4'd0;
      shreg    <= '0;
      timer    <= '0;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (fall) begin
        shreg <= frame[10:1];
        timer <= '0;
        if (bit_cnt == LAST) begin
          bit_cnt  <= 4'd0;
          rx_valid <= frame_ok;
          rx_error <= ~frame_ok;
          if (frame_ok) rx_byte <= frame[8:1];
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (timeout) begin
        bit_cnt  <= 4'd0;
        timer    <= '0;
        rx_error <= 1'b1;
      end else if (bit_cnt == 4'd0) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: rtl/keyboard_key_decoder.sv
// Make/break scancode decoder producing held-key levels for
// throttle, gear down, gear up and start.
module keyboard_key_decoder
  import keyboard_pkg::*;
#(
  parameter logic [7:0] KEY0_CODE = KEY0_DEF,
  parameter logic [7:0] KEY1_CODE = KEY1_DEF,
  parameter logic [7:0] KEY2_CODE = KEY2_DEF,
  parameter logic [7:0] KEY3_CODE = KEY3_DEF,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input logic clk,
  input logic rst,
  keyboard_key_decoder_if.master bus
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;
  logic [3:0] hit;
  logic [3:0] keys, keys_n;
  logic       is_ext, is_brk;
  dec_state_t state, state_n;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (bus.ps2_clk),
    .ps2_data(bus.ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_error(rx_error)
  );

  assign hit = {rx_byte == KEY3_CODE, rx_byte == KEY2_CODE,
                rx_byte == KEY1_CODE, rx_byte == KEY0_CODE};
  assign is_ext = (rx_byte == SC_EXT);
  assign is_brk = (rx_byte == SC_BREAK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      keys  <= 4'b0000;
    end else begin
      state <= state_n;
      keys  <= keys_n;
    end
  end

  always_comb begin
    state_n = state;
    keys_n  = keys;
    if (rx_error) begin
      state_n = ST_IDLE;
    end else if (rx_valid) begin
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            is_ext:  state_n = ST_EXT;
            is_brk:  state_n = ST_BREAK;
            default: keys_n  = keys | hit;
          endcase
        end
        ST_BREAK: begin
          keys_n  = keys & ~hit;
          state_n = ST_IDLE;
        end
        ST_EXT:
          state_n = is_brk ? ST_EXT_BREAK : ST_IDLE;
        ST_EXT_BREAK:
          state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.key_pressed = keys;
  assign bus.rx_byte     = rx_byte;
  assign bus.rx_valid    = rx_valid;
  assign bus.rx_error    = rx_error;

endmodule

// File: tb/tb_keyboard_key_decoder.sv
// Directed-vector bench for keyboard_key_decoder: frames are bit-banged
// on the PS/2 pins and decoded levels are checked against a table.
module tb_keyboard_key_decoder;

  localparam int TO = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keyboard_key_decoder_if bus ();

  keyboard_key_decoder #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  int vcnt = 0;
  int ecnt = 0;
  int both = 0;
  logic pend = 1'b0;
  logic [3:0] key_after = 4'h0;

  always @(negedge clk) begin
    if (bus.rx_valid) vcnt <= vcnt + 1;
    if (bus.rx_error) ecnt <= ecnt + 1;
    if (bus.rx_valid && bus.rx_error) both <= both + 1;
    if (pend) key_after <= bus.key_pressed;
    pend <= bus.rx_valid;
  end

  typedef struct {
    logic [7:0] code;
    logic       bad;
    int         nv;
    int         ne;
    logic [7:0] exp_byte;
    logic [3:0] exp_keys;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic d);
    bus.ps2_data = d;
    repeat (4) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (8) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic flip,
                      input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) bit_out(f[i]);
    bus.ps2_data = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int v0, e0;
    v0 = vcnt;
    e0 = ecnt;
    send(v.code, v.bad, 11);
    check($sformatf("v%0d valid", idx), vcnt - v0, v.nv);
    check($sformatf("v%0d error", idx), ecnt - e0, v.ne);
    check($sformatf("v%0d byte", idx), int'(bus.rx_byte),
          int'(v.exp_byte));
    check($sformatf("v%0d keys", idx), int'(bus.key_pressed),
          int'(v.exp_keys));
    if (v.nv == 1)
      check($sformatf("v%0d keys_t2", idx), int'(key_after),
            int'(v.exp_keys));
  endtask

  initial begin
    int v0, e0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;

    vecs.push_back('{8'h5A, 1'b0, 1, 0, 8'h5A, 4'b1000});
    vecs.push_back('{8'hF0, 1'b0, 1, 0, 8'hF0, 4'b1000});
    vecs.push_back('{8'h5A, 1'b0, 1, 0, 8'h5A, 4'b0000});
    vecs.push_back('{8'h1D, 1'b0, 1, 0, 8'h1D, 4'b0001});
    vecs.push_back('{8'h29, 1'b0, 1, 0, 8'h29, 4'b0101});
    vecs.push_back('{8'hF0, 1'b0, 1, 0, 8'hF0, 4'b0101});
    vecs.push_back('{8'h1D, 1'b0, 1, 0, 8'h1D, 4'b0100});
    vecs.push_back('{8'hF0, 1'b0, 1, 0, 8'hF0, 4'b0100});
    vecs.push_back('{8'h29, 1'b0, 1, 0, 8'h29, 4'b0000});
    vecs.push_back('{8'hE0, 1'b0, 1, 0, 8'hE0, 4'b0000});
    vecs.push_back('{8'h5A, 1'b0, 1, 0, 8'h5A, 4'b0000});
    vecs.push_back('{8'hE0, 1'b0, 1, 0, 8'hE0, 4'b0000});
    vecs.push_back('{8'hF0, 1'b0, 1, 0, 8'hF0, 4'b0000});
    vecs.push_back('{8'h5A, 1'b0, 1, 0, 8'h5A, 4'b0000});
    vecs.push_back('{8'h5A, 1'b0, 1, 0, 8'h5A, 4'b1000});
    vecs.push_back('{8'hF0, 1'b0, 1, 0, 8'hF0, 4'b1000});
    vecs.push_back('{8'h5A, 1'b0, 1, 0, 8'h5A, 4'b0000});
    vecs.push_back('{8'h1B, 1'b1, 0, 1, 8'h5A, 4'b0000});
    vecs.push_back('{8'h1B, 1'b0, 1, 0, 8'h1B, 4'b0010});

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst keys", int'(bus.key_pressed), 0);
    check("rst byte", int'(bus.rx_byte), 0);
    check("rst valid", int'(bus.rx_valid), 0);
    check("rst error", int'(bus.rx_error), 0);
    repeat (4) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Abandoned frame after 5 bits
    v0 = vcnt;
    e0 = ecnt;
    send(8'h29, 1'b0, 5);
    repeat (TO + 20) @(negedge clk);
    check("to error", ecnt - e0, 1);
    check("to valid", vcnt - v0, 0);
    check("to keys", int'(bus.key_pressed), 4'b0010);
    run_vec('{8'h29, 1'b0, 1, 0, 8'h29, 4'b0110}, 100);

    // Fill all keys, then reset mid-frame
    run_vec('{8'h1D, 1'b0, 1, 0, 8'h1D, 4'b0111}, 101);
    run_vec('{8'h5A, 1'b0, 1, 0, 8'h5A, 4'b1111}, 102);
    send(8'h1B, 1'b0, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst keys", int'(bus.key_pressed), 0);
    check("mrst byte", int'(bus.rx_byte), 0);
    check("mrst valid", int'(bus.rx_valid), 0);
    check("mrst error", int'(bus.rx_error), 0);
    repeat (4) @(negedge clk);
    run_vec('{8'h5A, 1'b0, 1, 0, 8'h5A, 4'b1000}, 103);

    check("valid+error overlap", both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/keyboard_key_decoder.md
# keyboard_key_decoder

Producer side of the keyboard path. Receives raw PS/2 frames from the keyboard pins, decodes make/break scancodes, and drives a 4-bit held-key level vector. That vector is the input to the game's per-key rising-edge detector, which feeds the drag-race control logic (start, throttle, gear up, gear down).

## Interface
- `KEY0_CODE`, default 8'h1D (W): scancode for key_pressed[0], throttle
- `KEY1_CODE`, default 8'h1B (S): scancode for key_pressed[1], gear down
- `KEY2_CODE`, default 8'h29 (Space): scancode for key_pressed[2], gear up
- `KEY3_CODE`, default 8'h5A (Enter): scancode for key_pressed[3], start
- `TIMEOUT_CYCLES`, default 100_000: idle clk cycles inside a frame before the frame is abandoned (1 ms at 100 MHz)

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  reset; synchronous, active-high
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous
- `key_pressed`  out  4  held level per mapped key; 1 from make code until break code
- `rx_byte`  out  8  last valid received byte
- `rx_valid`  out  1  one-cycle pulse when rx_byte updates
- `rx_error`  out  1  one-cycle pulse on a rejected frame (start, stop, parity or timeout)

## Operation
- Input conditioning: `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. A third register on the synced clock detects its falling edge (`fall`). Data is sampled only on `fall`.
- Frame: 11 bits. Start is 0, then 8 data bits LSB first, then odd parity, then stop 1. The bit counter runs 0..10.
- Frame checks are made at bit 10:
  - start==0, stop==1 and odd parity over data+parity: pulse rx_valid and load rx_byte.
  - Any check fails: pulse rx_error and leave rx_byte unchanged.
  - In both cases the bit counter returns to 0.
- Timeout: while the bit counter is nonzero, a timer counts clk cycles since the last `fall`. When it reaches TIMEOUT_CYCLES, the counter resets to 0, rx_error pulses, and the prefix flags clear. The timer is idle at count 0.
- Decoder FSM runs on each rx_valid. States are IDLE, BREAK, EXT, EXT_BREAK.
  - IDLE: byte E0 goes to EXT. Byte F0 goes to BREAK. Any other byte, if it matches a KEYn_CODE, sets key_pressed[n]; the state stays IDLE.
  - BREAK: a matching byte clears key_pressed[n]. Any byte returns to IDLE.
  - EXT: byte F0 goes to EXT_BREAK. Any other byte returns to IDLE with no key change.
  - EXT_BREAK: any byte returns to IDLE with no key change. Extended keys are never mapped, so E0 5A does not assert key 3.
- Repeated make codes (typematic) while a key is held re-set an already-set bit; no output change.
- If two KEYn_CODE parameters are equal, both bits follow that scancode.
- rx_error, or a timeout, forces the FSM to IDLE. key_pressed is kept.
- Several keys may be held at once; bits are independent.

## Timing
- Reset values: key_pressed=4'b0000, rx_byte=8'h00, rx_valid=0, rx_error=0. FSM=IDLE, bit counter=0, timer=0, synchronizer flops=1 (bus idle high).
- Reset mid-frame discards the partial frame and all key state.
- `fall` is asserted 3 clk after the ps2_clk pin falls: 2 sync flops plus 1 edge register.
- rx_valid/rx_error pulse on the cycle after the `fall` that samples bit 10.
- key_pressed changes on the cycle after rx_valid. So key_pressed is valid 2 clk after the stop-bit `fall`.
- rx_valid and rx_error are never high in the same cycle. Each is exactly 1 cycle wide.
- If a timeout and a `fall` occur in the same cycle, the `fall` wins and the timer restarts.

## Structure
- Package `keyboard_pkg` holds:
  - prefix constants SC_BREAK=8'hF0 and SC_EXT=8'hE0;
  - default key scancodes;
  - the decoder state enum;
  - the frame length constant 11.
- Sub-module `ps2_rx` contains the synchronizers, falling-edge detect, bit counter, shift register, parity/start/stop check, and timeout timer. It outputs rx_byte, rx_valid and rx_error.
- The top level instantiates `ps2_rx` and contains the decoder FSM and the key_pressed register.

## Test plan
- Send frame 8'h5A with good parity -> rx_valid pulses once, rx_byte=8'h5A, key_pressed=4'b1000 two clk after the stop `fall`. Then send F0, 5A -> key_pressed=4'b0000.
- Send 1D then 29 -> key_pressed=4'b0101. Then send F0, 1D -> key_pressed=4'b0100.
- Send E0, 5A -> key_pressed stays 4'b0000. Then send E0, F0, 5A -> stays 4'b0000; FSM ends in IDLE.
- Send 8'h1B with the parity bit flipped -> rx_error pulses once, no rx_valid, rx_byte and key_pressed unchanged. A following good 1B -> key_pressed[1]=1.
- Stop ps2_clk after 5 bits, wait TIMEOUT_CYCLES -> rx_error pulses once. A following complete 29 frame decodes -> key_pressed[2]=1.
- With key_pressed=4'b1111, assert rst for 1 cycle mid-frame -> all outputs 0 on the next cycle. The next full 5A frame decodes correctly.
